// File: rtl/freelist_mw_pkg.sv
// -----------------------------------------------------------------------------
// freelist_mw_pkg
// Shared definitions for the multi-way physical register free list.
//   - Sizing constants: register counts, lane count, checkpoint count and the
//     derived pointer/index widths.
//   - Packet structs grouping the rename-side request fields
//     (alloc, free, checkpoint, rollback) and the response fields
//     (grant, PRs, occupancy).
//   - Small helper to turn a wrap-bit pointer into a storage index.
// -----------------------------------------------------------------------------
package freelist_mw_pkg;

  localparam int NUM_PR   = 64;                 // physical registers
  localparam int NUM_AR   = 32;                 // architectural registers
  localparam int WAYS     = 2;                  // alloc lanes and free lanes
  localparam int NUM_CKPT = 4;                  // branch checkpoints

  localparam int PR_W     = $clog2(NUM_PR);
  localparam int CK_W     = $clog2(NUM_CKPT);
  localparam int FL_DEPTH = NUM_PR - NUM_AR;    // must be a power of two
  localparam int FL_IDX_W = $clog2(FL_DEPTH);   // storage index width
  localparam int P_W      = FL_IDX_W + 1;       // pointer width incl. wrap bit
  localparam int CNT_W    = $clog2(WAYS + 1);   // lane count width (0..WAYS)

  typedef logic [PR_W-1:0]     pr_t;
  typedef logic [P_W-1:0]      ptr_t;
  typedef logic [FL_IDX_W-1:0] idx_t;

  // Request bundle driven by rename/retire toward the free list.
  typedef struct packed {
    logic [WAYS-1:0] alloc_req;
    logic [WAYS-1:0] free_valid;
    pr_t  [WAYS-1:0] free_pr;
    logic            ckpt_save;
    logic [CK_W-1:0] ckpt_id;
    logic            rollback;
    logic [CK_W-1:0] rb_id;
  } freelist_packet_in_t;

  // Response bundle returned by the free list.
  typedef struct packed {
    logic            alloc_grant;
    pr_t  [WAYS-1:0] alloc_pr;
    ptr_t            free_count;
  } freelist_packet_out_t;

  // The low bits of a wrap-bit pointer address the circular storage.
  function automatic idx_t ptr_idx(input ptr_t p);
    return p[FL_IDX_W-1:0];
  endfunction

endpackage

// File: rtl/freelist_mw_if.sv
// -----------------------------------------------------------------------------
// freelist_mw_if
// Bundles the free-list request and response packets.
//   req : freelist_packet_in_t  (alloc_req, free_valid/free_pr, ckpt_save/id,
//                                rollback/rb_id)
//   rsp : freelist_packet_out_t (alloc_grant, alloc_pr, free_count)
// Modports:
//   master : rename/retire side, drives req, observes rsp
//   slave  : free list, observes req, drives rsp
// -----------------------------------------------------------------------------
interface freelist_mw_if;
  import freelist_mw_pkg::*;

  freelist_packet_in_t  req;
  freelist_packet_out_t rsp;

  modport master (output req, input rsp);
  modport slave  (input req, output rsp);

endinterface

// File: rtl/freelist_mw_lane_prefix_count.sv
// -----------------------------------------------------------------------------
// lane_prefix_count
// Per-lane exclusive prefix count of a lane mask plus its total popcount.
// Used to compact active lanes onto consecutive FIFO slots.
// Ports:
//   mask_i   in  WAYS          lane active mask
//   prefix_o out WAYS x CNT_W  number of active lanes strictly below each lane
//   total_o  out CNT_W         number of active lanes
// -----------------------------------------------------------------------------
module lane_prefix_count #(
  parameter int WAYS  = 2,
  parameter int CNT_W = $clog2(WAYS + 1)
) (
  input  logic [WAYS-1:0]            mask_i,
  output logic [WAYS-1:0][CNT_W-1:0] prefix_o,
  output logic [CNT_W-1:0]           total_o
);

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_lane
    // Bits of all lanes below gi.
    localparam logic [WAYS-1:0] BELOW = WAYS'((1 << gi) - 1);
    assign prefix_o[gi] = CNT_W'($countones(mask_i & BELOW));
  end

  assign total_o = CNT_W'($countones(mask_i));

endmodule

// File: rtl/freelist_mw.sv
// -----------------------------------------------------------------------------
// freelist_mw
// Multi-way physical register free list for an R10000-style rename stage.
// Circular FIFO of FL_DEPTH PR numbers: head hands PRs to dispatch
// (all-or-nothing, up to WAYS per cycle), tail takes PRs back from retire
// (up to WAYS per cycle). The head pointer can be snapshotted into branch
// checkpoints and restored in one cycle on a mispredict.
// Ports:
//   clk_i   in  system clock, rising edge
//   rst_ni  in  asynchronous active-low reset
//   en_i    in  stage enable; 0 freezes all state and blocks grants
//   fl_if   slave modport: req (alloc/free/ckpt/rollback) in,
//           rsp (alloc_grant, alloc_pr, free_count) out
// -----------------------------------------------------------------------------
module freelist_mw
  import freelist_mw_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  freelist_mw_if.slave fl_if
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  pr_t                 entry_q [FL_DEPTH];
  ptr_t                head_q, head_d;
  ptr_t                tail_q, tail_d;
  ptr_t                ckpt_q  [NUM_CKPT];
  logic [NUM_CKPT-1:0] ckpt_saved_q;   // slots written since reset

  // ---------------------------------------------------------------------------
  // Lane compaction
  // ---------------------------------------------------------------------------
  logic [WAYS-1:0][CNT_W-1:0] alloc_ofs;
  logic [WAYS-1:0][CNT_W-1:0] free_ofs;
  logic [CNT_W-1:0]           alloc_n;
  logic [CNT_W-1:0]           free_n;

  lane_prefix_count #(
    .WAYS  (WAYS),
    .CNT_W (CNT_W)
  ) u_alloc_pfx (
    .mask_i   (fl_if.req.alloc_req),
    .prefix_o (alloc_ofs),
    .total_o  (alloc_n)
  );

  lane_prefix_count #(
    .WAYS  (WAYS),
    .CNT_W (CNT_W)
  ) u_free_pfx (
    .mask_i   (fl_if.req.free_valid),
    .prefix_o (free_ofs),
    .total_o  (free_n)
  );

  // ---------------------------------------------------------------------------
  // Allocation (combinational from current state)
  // ---------------------------------------------------------------------------
  ptr_t            free_count;
  logic            alloc_grant;
  ptr_t            head_after_alloc;
  idx_t [WAYS-1:0] rd_idx;
  idx_t [WAYS-1:0] wr_idx;
  pr_t  [WAYS-1:0] alloc_pr;

  // Wrap bit makes tail - head exact over 0..FL_DEPTH.
  assign free_count  = tail_q - head_q;

  // A rollback squashes the same-cycle allocation; frees of this cycle are
  // not visible yet, so an empty list never grants.
  assign alloc_grant = en_i & ~fl_if.req.rollback &
                       (P_W'(alloc_n) <= free_count);

  assign head_after_alloc = alloc_grant ? head_q + P_W'(alloc_n) : head_q;

  always_comb begin
    rd_idx   = '0;
    wr_idx   = '0;
    alloc_pr = '0;
    for (int i = 0; i < WAYS; i++) begin
      rd_idx[i] = ptr_idx(head_q + P_W'(alloc_ofs[i]));
      wr_idx[i] = ptr_idx(tail_q + P_W'(free_ofs[i]));
      if (fl_if.req.alloc_req[i]) begin
        alloc_pr[i] = entry_q[rd_idx[i]];
      end
    end
  end

  assign fl_if.rsp = '{alloc_grant: alloc_grant,
                       alloc_pr:    alloc_pr,
                       free_count:  free_count};

  // ---------------------------------------------------------------------------
  // Pointer next state
  // ---------------------------------------------------------------------------
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (en_i) begin
      tail_d = tail_q + P_W'(free_n);
      head_d = fl_if.req.rollback ? ckpt_q[fl_if.req.rb_id] : head_after_alloc;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q       <= '0;
      tail_q       <= ptr_t'(FL_DEPTH);
      ckpt_saved_q <= '0;
      for (int i = 0; i < FL_DEPTH; i++) begin
        entry_q[i] <= pr_t'(NUM_AR + i);
      end
      for (int i = 0; i < NUM_CKPT; i++) begin
        ckpt_q[i] <= '0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      if (en_i) begin
        for (int i = 0; i < WAYS; i++) begin
          if (fl_if.req.free_valid[i]) begin
            entry_q[wr_idx[i]] <= fl_if.req.free_pr[i];
          end
        end
        // Snapshot includes this cycle's granted allocations.
        if (fl_if.req.ckpt_save && !fl_if.req.rollback) begin
          ckpt_q[fl_if.req.ckpt_id]       <= head_after_alloc;
          ckpt_saved_q[fl_if.req.ckpt_id] <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Usage checks (protocol errors are not handled in logic)
  // ---------------------------------------------------------------------------
  ptr_t occ_next;
  assign occ_next = tail_d - head_d;

  a_no_overfill : assert property (@(posedge clk_i) disable iff (!rst_ni)
    occ_next <= ptr_t'(FL_DEPTH));

  a_rollback_saved : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (en_i && fl_if.req.rollback) |-> ckpt_saved_q[fl_if.req.rb_id]);

endmodule

// File: tb/tb_freelist_mw.sv
module tb_freelist_mw;
  import freelist_mw_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en    = 1'b0;

  freelist_mw_if fl_if ();

  freelist_mw dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .en_i   (en),
    .fl_if  (fl_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: unbounded allocation/free counters over a ring of PRs.
  // ---------------------------------------------------------------------------
  int ring [FL_DEPTH];
  int m_alloc_cnt;
  int m_free_cnt;
  int m_ck [NUM_CKPT];
  bit m_ck_ok [NUM_CKPT];
  int last_pr [WAYS];

  task automatic model_reset();
    for (int i = 0; i < FL_DEPTH; i++) ring[i] = NUM_AR + i;
    m_alloc_cnt = 0;
    m_free_cnt  = FL_DEPTH;
    for (int i = 0; i < NUM_CKPT; i++) begin
      m_ck[i] = 0;
      m_ck_ok[i] = 1'b0;
    end
  endtask

  // Apply inputs at negedge; outputs settle by #1 before the next posedge.
  task automatic drive(input bit e, input logic [1:0] req, input logic [1:0] fv,
                       input int f0, input int f1, input bit sv, input int sid,
                       input bit rb, input int rid);
    @(negedge clk);
    en                      = e;
    fl_if.req.alloc_req     = req;
    fl_if.req.free_valid    = fv;
    fl_if.req.free_pr[0]    = PR_W'(f0);
    fl_if.req.free_pr[1]    = PR_W'(f1);
    fl_if.req.ckpt_save     = sv;
    fl_if.req.ckpt_id       = CK_W'(sid);
    fl_if.req.rollback      = rb;
    fl_if.req.rb_id         = CK_W'(rid);
    #1;
  endtask

  task automatic idle_inputs();
    en        = 1'b0;
    fl_if.req = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    chk("reset_free_count", int'(fl_if.rsp.free_count), FL_DEPTH);
    chk("reset_grant_disabled", int'(fl_if.rsp.alloc_grant), 0);
  endtask

  // One model-checked cycle.
  task automatic mstep(input bit e, input logic [1:0] req, input logic [1:0] fv,
                       input int f0, input int f1, input bit sv, input int sid,
                       input bit rb, input int rid);
    int fc, n, k, nf, nxt;
    bit g;
    int epr [WAYS];
    int fpr [WAYS];
    fpr[0] = f0;
    fpr[1] = f1;
    drive(e, req, fv, f0, f1, sv, sid, rb, rid);
    fc = m_free_cnt - m_alloc_cnt;
    n  = $countones(req);
    g  = e && !rb && (n <= fc);
    k  = 0;
    for (int i = 0; i < WAYS; i++) begin
      epr[i] = 0;
      if (req[i]) begin
        epr[i] = ring[(m_alloc_cnt + k) % FL_DEPTH];
        k++;
      end
    end
    chk("m_grant", int'(fl_if.rsp.alloc_grant), int'(g));
    chk("m_free_count", int'(fl_if.rsp.free_count), fc);
    for (int i = 0; i < WAYS; i++) begin
      if (!req[i]) chk("m_idle_lane_pr", int'(fl_if.rsp.alloc_pr[i]), 0);
      else if (g) chk("m_alloc_pr", int'(fl_if.rsp.alloc_pr[i]), epr[i]);
      last_pr[i] = epr[i];
    end
    $display("cyc en=%0d req=%b fv=%b sv=%0d rb=%0d grant=%0d pr0=%0d pr1=%0d fc=%0d",
             e, req, fv, sv, rb, fl_if.rsp.alloc_grant, fl_if.rsp.alloc_pr[0],
             fl_if.rsp.alloc_pr[1], fl_if.rsp.free_count);
    @(posedge clk);
    if (e) begin
      nxt = g ? m_alloc_cnt + n : m_alloc_cnt;
      if (sv && !rb) begin
        m_ck[sid]    = nxt;
        m_ck_ok[sid] = 1'b1;
      end
      if (rb) nxt = m_ck[rid];
      nf = 0;
      for (int i = 0; i < WAYS; i++) begin
        if (fv[i]) begin
          ring[(m_free_cnt + nf) % FL_DEPTH] = fpr[i];
          nf++;
        end
      end
      m_free_cnt  += nf;
      m_alloc_cnt  = nxt;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    bit         en;
    logic [1:0] req;
    logic [1:0] fv;
    int         f0, f1;
    bit         rb;
    int         rid;
    bit         exp_grant;
    int         exp_pr0, exp_pr1;   // -1: not checked
    int         exp_fc;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input bit e, input logic [1:0] req, input logic [1:0] fv,
                         input int f0, input int f1, input bit rb, input int rid,
                         input bit eg, input int p0, input int p1, input int fc);
    vec_t v;
    v = '{en: e, req: req, fv: fv, f0: f0, f1: f1, rb: rb, rid: rid,
          exp_grant: eg, exp_pr0: p0, exp_pr1: p1, exp_fc: fc};
    vecs.push_back(v);
  endtask

  task automatic hand(input string nm, input bit e, input logic [1:0] req,
                      input logic [1:0] fv, input int f0, input int f1,
                      input bit sv, input int sid, input bit rb, input int rid,
                      input int eg, input int p0, input int p1, input int fc);
    drive(e, req, fv, f0, f1, sv, sid, rb, rid);
    if (eg >= 0) chk({nm, "_grant"}, int'(fl_if.rsp.alloc_grant), eg);
    if (p0 >= 0) chk({nm, "_pr0"}, int'(fl_if.rsp.alloc_pr[0]), p0);
    if (p1 >= 0) chk({nm, "_pr1"}, int'(fl_if.rsp.alloc_pr[1]), p1);
    if (fc >= 0) chk({nm, "_fc"}, int'(fl_if.rsp.free_count), fc);
    $display("%s grant=%0d pr0=%0d pr1=%0d fc=%0d", nm, fl_if.rsp.alloc_grant,
             fl_if.rsp.alloc_pr[0], fl_if.rsp.alloc_pr[1], fl_if.rsp.free_count);
    @(posedge clk);
  endtask

  initial begin
    logic [1:0] rq, fv;
    int room, nf, rid, ftn;
    bit rb, e;

    idle_inputs();

    // ---- table: fill, drain-to-empty, free/alloc ordering, partial masks ----
    for (int k = 0; k < 16; k++)
      add_vec(1, 2'b11, 2'b00, 0, 0, 0, 0, 1, 32 + 2*k, 33 + 2*k, 32 - 2*k);
    add_vec(1, 2'b11, 2'b11, 9, 5, 0, 0, 0, -1, -1, 0);   // empty: frees not bypassed
    add_vec(1, 2'b11, 2'b00, 0, 0, 0, 0, 1, 9, 5, 2);     // lane-0 free comes out first
    add_vec(1, 2'b00, 2'b01, 63, 0, 0, 0, 1, 0, 0, 0);    // n=0 always granted
    add_vec(1, 2'b11, 2'b00, 0, 0, 0, 0, 0, -1, -1, 1);   // 2 > 1 free: all-or-nothing
    add_vec(1, 2'b10, 2'b00, 0, 0, 0, 0, 1, 0, 63, 1);    // lane 1 alone gets head
    add_vec(1, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0);
    add_vec(0, 2'b01, 2'b01, 3, 0, 1, 0, 0, -1, 0, 0);    // disabled: everything ignored
    add_vec(1, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0);

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].en, vecs[i].req, vecs[i].fv, vecs[i].f0, vecs[i].f1,
            0, 0, vecs[i].rb, vecs[i].rid);
      chk($sformatf("vec%0d_grant", i), int'(fl_if.rsp.alloc_grant), int'(vecs[i].exp_grant));
      chk($sformatf("vec%0d_fc", i), int'(fl_if.rsp.free_count), vecs[i].exp_fc);
      if (vecs[i].exp_pr0 >= 0)
        chk($sformatf("vec%0d_pr0", i), int'(fl_if.rsp.alloc_pr[0]), vecs[i].exp_pr0);
      if (vecs[i].exp_pr1 >= 0)
        chk($sformatf("vec%0d_pr1", i), int'(fl_if.rsp.alloc_pr[1]), vecs[i].exp_pr1);
      $display("vec%0d req=%b fv=%b grant=%0d pr0=%0d pr1=%0d fc=%0d", i,
               vecs[i].req, vecs[i].fv, fl_if.rsp.alloc_grant,
               fl_if.rsp.alloc_pr[0], fl_if.rsp.alloc_pr[1], fl_if.rsp.free_count);
      @(posedge clk);
    end

    // ---- checkpoint / rollback sequence ----
    do_reset();
    hand("ck_a0", 1, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 1, 32, 33, 32);
    hand("ck_a1", 1, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 1, 34, 35, 30);
    hand("ck_save", 1, 2'b00, 2'b00, 0, 0, 1, 2, 0, 0, 1, -1, -1, 28);
    hand("ck_a2", 1, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 1, 36, 37, 28);
    hand("ck_a3", 1, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 1, 38, 39, 26);
    hand("ck_a4", 1, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 1, 40, 41, 24);
    hand("ck_rb", 1, 2'b11, 2'b01, 7, 0, 0, 0, 1, 2, 0, -1, -1, 22);
    hand("ck_after_rb", 1, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 1, 36, 0, 29);
    hand("rbsave", 1, 2'b11, 2'b00, 0, 0, 1, 2, 1, 2, 0, -1, -1, 28);
    hand("rbsave_head", 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1, -1, -1, 29);
    hand("rbsave_rb2", 1, 2'b00, 2'b00, 0, 0, 0, 0, 1, 2, 0, -1, -1, 29);
    hand("rbsave_slot", 1, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 1, 36, 37, 29);

    // ---- wrap-around: steady alloc 2 / free 2, then async reset ----
    do_reset();
    mstep(1, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 40; c++) begin
      mstep(1, 2'b11, 2'b11, last_pr[0], last_pr[1], 0, 0, 0, 0);
      chk("wrap_fc_const", int'(fl_if.rsp.free_count), 30);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_reset_fc", int'(fl_if.rsp.free_count), FL_DEPTH);
    $display("async reset fc=%0d", fl_if.rsp.free_count);

    // ---- randomized against the model ----
    do_reset();
    for (int c = 0; c < 400; c++) begin
      e    = ($urandom_range(0, 9) != 0);
      rq   = 2'($urandom);
      fv   = 2'($urandom);
      room = FL_DEPTH - (m_free_cnt - m_alloc_cnt);
      while ($countones(fv) > room) fv = fv & (fv - 2'd1);
      nf   = e ? $countones(fv) : 0;
      rb   = ($urandom_range(0, 7) == 0);
      rid  = $urandom_range(0, NUM_CKPT - 1);
      ftn  = m_free_cnt + nf;
      if (!m_ck_ok[rid] || (ftn - m_ck[rid]) > FL_DEPTH || (ftn - m_ck[rid]) < 0)
        rb = 1'b0;
      mstep(e, rq, fv, $urandom_range(0, NUM_PR - 1), $urandom_range(0, NUM_PR - 1),
            ($urandom_range(0, 3) == 0), $urandom_range(0, NUM_CKPT - 1), rb, rid);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Hard time bound so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/freelist_mw.md
# freelist_mw

Multi-way physical register free list for the R10000-style rename stage.
- Hands out up to WAYS free physical registers (PRs) per cycle to dispatch and accepts up to WAYS PRs per cycle back from retirement.
- Snapshots its allocation pointer into per-branch checkpoints so that a mispredict restores the list in one cycle.
- Sits between the decode/rename logic (map table) and the ROB retire port.

## Interface
Parameters:
- NUM_PR, 64, physical registers; PR_W = $clog2(NUM_PR)
- NUM_AR, 32, architectural registers; PRs 0..NUM_AR-1 are mapped at reset
- WAYS, 2, allocate lanes and free lanes per cycle
- NUM_CKPT, 4, branch checkpoints; CK_W = $clog2(NUM_CKPT)
- FL_DEPTH = NUM_PR-NUM_AR (derived, must be a power of two); P_W = $clog2(FL_DEPTH)+1

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low (asserted when 0)
- en  in  1  global stage enable; 0 freezes all state
- alloc_req  in  WAYS  per-lane allocate request, any mask
- alloc_grant  out  1  all requested lanes granted this cycle
- alloc_pr  out  WAYS x PR_W  PR for each requesting lane
- free_valid  in  WAYS  per-lane retire free
- free_pr  in  WAYS x PR_W  PR being returned
- ckpt_save  in  1  snapshot the head pointer into ckpt_id
- ckpt_id  in  CK_W  checkpoint slot to write
- rollback  in  1  restore the head pointer from rb_id
- rb_id  in  CK_W  checkpoint slot to read
- free_count  out  P_W  current number of free PRs

## Operation
- Storage is a circular FIFO of FL_DEPTH PR numbers.
  - head (P_W bits, with wrap bit) is the next PR to allocate.
  - tail is the next slot to write.
  - free_count = tail - head.
- Reset: entry i = NUM_AR+i, head = 0, tail = FL_DEPTH, all checkpoints = 0.
- Allocation is all-or-nothing.
  - n = popcount(alloc_req).
  - alloc_grant = en & !rollback & (n <= free_count). It is 1 when n = 0.
  - Requesting lane i receives entry[head + (number of requesting lanes below i)].
  - Non-requesting lanes drive alloc_pr = 0.
  - On a grant, head += n.
- Free:
  - Valid lanes are compacted in lane order.
  - entry[tail + k] = free_pr of the k-th valid lane.
  - tail += popcount(free_valid).
  - Frees are non-speculative and always applied when en = 1, including during a rollback.
- Checkpoint: ckpt[ckpt_id] <= head after this cycle's granted allocations.
- Rollback:
  - head <= ckpt[rb_id].
  - Same-cycle allocations are dropped (alloc_grant = 0).
  - Same-cycle ckpt_save is ignored.
  - tail is unaffected.
- en = 0: head, tail, entries and checkpoints hold; alloc_grant = 0; frees and rollback are ignored. Upstream must hold them until en = 1.

## Timing
- alloc_grant and alloc_pr are combinational from alloc_req and the current state, with no registered latency. Their values are valid in the same cycle.
- A PR freed in cycle t is allocatable from cycle t+1. There is no free-to-alloc bypass.
- A rollback in cycle t makes checkpointed registers allocatable at t+1. free_count updates at t+1.
- free_count reflects registered state only. Its reset value is FL_DEPTH.
- Wrap-around: pointers wrap modulo FL_DEPTH using the wrap bit. free_count = 0 means empty; free_count = FL_DEPTH means full.
- Simultaneous events:
  - Allocation and free in the same cycle: both apply.
  - With free_count = 0 and any alloc_req: alloc_grant = 0, even if frees arrive that cycle.
- Error conditions, checked by assertions and not handled in RTL:
  - A free that would exceed FL_DEPTH.
  - Rollback to a slot never saved since reset.
- Reset asserted mid-operation returns all state to reset values immediately (asynchronous). Outputs are valid from the first edge after release.

## Structure
- Shared header (sys_defs): NUM_PR, NUM_AR, WAYS, NUM_CKPT, PR_W, and the FREELIST_PACKET_IN / FREELIST_PACKET_OUT structs grouping the alloc, free, checkpoint and rollback fields.
- Sub-module lane_prefix_count: WAYS-bit mask in, per-lane exclusive prefix count and total popcount out. It is instantiated twice, once for alloc lanes and once for free lanes.

## Test plan
- Reset, then allocate 2 lanes each cycle for 16 cycles -> PRs 32,33,…,63 granted in order; free_count 32→0; 17th request gets alloc_grant = 0.
- free_count = 1 with alloc_req = 2'b11 -> alloc_grant = 0, head unchanged. Then alloc_req = 2'b10 -> lane 1 gets PR 63, lane 0 alloc_pr = 0.
- free_count = 0 with free_valid = 2'b11, free_pr = {5,9} in the same cycle as an alloc request -> no grant. Next cycle a 2-lane allocation returns PR 9 (lane 0), then 5 (lane 1)… per compaction order, i.e. lane0-free first: lane 0 gets 9, lane 1 gets 5.
- ckpt_save slot 2 at head = 4, then allocate 6 PRs, then rollback rb_id = 2 with free_valid = 1 (PR 7) -> head = 4, free_count = 29, and the next allocation returns PR 36.
- rollback and ckpt_save together, plus alloc_req = 2'b11 -> no grant, checkpoint slot unchanged, head restored.
- Drive the pointers past FL_DEPTH with alternating alloc/free of 2 per cycle for 40 cycles -> free_count constant, PRs returned in FIFO order across the wrap. Assert reset = 0 mid-run -> free_count = 32 immediately.
